net_feeder: RTL and testbench

//  Synthesizable frame front-end for net_proc: accepts a pixel stream on a valid/ready port and clears net_proc's

---
 rtl/net_feeder.sv | 173 +++++++++++++++++
 tb/tb_net_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_feeder.sv
`timescale 1ns/1ps
// Frame front-end for net_proc: clears its input memory, writes one pixel frame,
// starts the network and returns the class index on a valid/ready result port.
module net_feeder #(
   parameter int N_PIXELS   = 784,
   parameter int DATA_W     = 8,
   parameter int IDX_W      = 4,
   parameter int GAP_CYCLES = 0,
   parameter int AUTO_START = 1,
   parameter int TIMEOUT    = 2**20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              start_req,
   output logic              busy,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [IDX_W-1:0]  m_result,
   output logic              err_short,
   output logic              err_long,
   output logic              err_timeout,
   output logic              net_mem_rst,
   output logic              net_mem_we,
   output logic [DATA_W-1:0] net_mem_wdata,
   output logic              net_start,
   input  logic              net_done,
   input  logic [IDX_W-1:0]  net_result,
   output logic [2:0]        dbg_state
);
   // Handshake rule for both ports: a transfer happens on a rising clk edge
   // where valid and ready are both 1; valid/data hold until that edge.

   localparam int CNT_W = $clog2(N_PIXELS + 1);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);
   localparam logic [TMO_W-1:0] TMO_VAL  = TMO_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_PAD, S_DRAIN, S_TRIG, S_START, S_RUN
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [GAP_W-1:0]  gap;
   logic [TMO_W-1:0]  tcnt;
   logic              armed;

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         gap           <= '0;
         tcnt          <= '0;
         armed         <= 1'b0;
         s_ready       <= 1'b0;
         busy          <= 1'b0;
         m_valid       <= 1'b0;
         m_result      <= '0;
         err_short     <= 1'b0;
         err_long      <= 1'b0;
         err_timeout   <= 1'b0;
         net_mem_rst   <= 1'b0;
         net_mem_we    <= 1'b0;
         net_mem_wdata <= '0;
         net_start     <= 1'b0;
      end else begin
         net_mem_rst <= 1'b0;
         net_mem_we  <= 1'b0;
         net_start   <= 1'b0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         err_timeout <= 1'b0;
         // A manual start is re-armed only after start_req has been seen low.
         if (!start_req) armed <= 1'b1;
         if (m_valid && m_ready) m_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (s_valid) begin
                  state       <= S_CLEAR;
                  net_mem_rst <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_CLEAR: begin
               state   <= S_LOAD;
               s_ready <= 1'b1;
               cnt     <= '0;
               gap     <= '0;
            end
            S_LOAD: begin
               if (s_valid && s_ready) begin
                  net_mem_we    <= 1'b1;
                  net_mem_wdata <= s_data;
                  cnt           <= cnt + CNT_W'(1);
                  gap           <= GAP_INIT;
                  s_ready       <= (GAP_CYCLES == 0);
                  if (cnt == LAST_IDX) begin
                     if (s_last) begin
                        state   <= S_TRIG;
                        s_ready <= 1'b0;
                     end else begin
                        err_long <= 1'b1;
                        state    <= S_DRAIN;
                        s_ready  <= 1'b1;
                     end
                  end else if (s_last) begin
                     err_short <= 1'b1;
                     state     <= S_PAD;
                     s_ready   <= 1'b0;
                  end
               end else if (gap != '0) begin
                  gap     <= gap - GAP_W'(1);
                  s_ready <= (gap == GAP_W'(1));
               end
            end
            S_PAD: begin
               // Short frame: fill the rest of memory with zeros at pixel pace.
               if (gap != '0) begin
                  gap <= gap - GAP_W'(1);
               end else begin
                  net_mem_we    <= 1'b1;
                  net_mem_wdata <= '0;
                  cnt           <= cnt + CNT_W'(1);
                  gap           <= GAP_INIT;
                  if (cnt == LAST_IDX) state <= S_TRIG;
               end
            end
            S_DRAIN: begin
               if (s_valid && s_ready && s_last) begin
                  state   <= S_TRIG;
                  s_ready <= 1'b0;
               end
            end
            S_TRIG: begin
               if (!m_valid && ((AUTO_START != 0) || (start_req && armed))) begin
                  net_start <= 1'b1;
                  armed     <= 1'b0;
                  state     <= S_START;
               end
            end
            S_START: begin
               state <= S_RUN;
               tcnt  <= TMO_W'(1);
            end
            S_RUN: begin
               if (net_done) begin
                  m_result <= net_result;
                  m_valid  <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else if (TIMEOUT != 0 && tcnt == TMO_VAL) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TMO_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_net_feeder.sv
`timescale 1ns/1ps
// Bench for net_feeder: a behavioural net_proc/memory model feeds a write and
// result scoreboard; a second small instance covers write pacing and manual start.
module tb_net_feeder;
   localparam int N    = 784;
   localparam int TMO  = 100;
   localparam int GN   = 8;
   localparam int GGAP = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main instance
   logic       s_valid, s_ready, s_last, start_req, busy, m_valid, m_ready;
   logic [7:0] s_data, net_mem_wdata;
   logic [3:0] m_result, net_result;
   logic       err_short, err_long, err_timeout, net_mem_rst, net_mem_we, net_start, net_done;
   logic [2:0] dbg_state;

   net_feeder #(.N_PIXELS(N), .DATA_W(8), .IDX_W(4), .GAP_CYCLES(0), .AUTO_START(1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .start_req(start_req), .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
      .err_short(err_short), .err_long(err_long), .err_timeout(err_timeout), .net_mem_rst(net_mem_rst),
      .net_mem_we(net_mem_we), .net_mem_wdata(net_mem_wdata), .net_start(net_start), .net_done(net_done),
      .net_result(net_result), .dbg_state(dbg_state));

   // paced, manual-start instance
   logic       g_s_valid, g_s_ready, g_s_last, g_start_req, g_busy, g_m_valid, g_m_ready;
   logic [7:0] g_s_data, g_net_mem_wdata;
   logic [3:0] g_m_result, g_net_result;
   logic       g_err_short, g_err_long, g_err_timeout, g_net_mem_rst, g_net_mem_we, g_net_start, g_net_done;
   logic [2:0] g_dbg_state;

   net_feeder #(.N_PIXELS(GN), .DATA_W(8), .IDX_W(4), .GAP_CYCLES(GGAP), .AUTO_START(0), .TIMEOUT(0)) g_dut (
      .clk(clk), .rst_n(rst_n), .s_valid(g_s_valid), .s_ready(g_s_ready), .s_data(g_s_data), .s_last(g_s_last),
      .start_req(g_start_req), .busy(g_busy), .m_valid(g_m_valid), .m_ready(g_m_ready), .m_result(g_m_result),
      .err_short(g_err_short), .err_long(g_err_long), .err_timeout(g_err_timeout), .net_mem_rst(g_net_mem_rst),
      .net_mem_we(g_net_mem_we), .net_mem_wdata(g_net_mem_wdata), .net_start(g_net_start), .net_done(g_net_done),
      .net_result(g_net_result), .dbg_state(g_dbg_state));

   // scoreboard state
   int checks = 0, errors = 0;
   int cyc = 0;
   logic [7:0] exp_w_q[$];
   logic [3:0] exp_res_q[$];
   int net_q[$], dly_q[$];
   int exp_short = 0, exp_long = 0, exp_tmo = 0, exp_rst = 0, exp_start = 0;
   int got_short = 0, got_long = 0, got_tmo = 0, rst_cnt = 0, start_cnt = 0;
   int we_cnt = 0, start_cyc = 0;
   bit hs_prev = 0, held = 0, rdy_force0 = 0;
   logic [3:0] held_val, mon_r;
   logic [7:0] mon_w;

   always @(posedge clk) cyc++;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic report_and_finish();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   function automatic logic [10:0] main_outs();
      return {s_ready, busy, m_valid, err_short, err_long, err_timeout,
              net_mem_rst, net_mem_we, net_start, |net_mem_wdata, |m_result};
   endfunction

   // random result-port back-pressure
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_ready = rdy_force0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // behavioural net_proc: answers each start after a chosen delay, or never (-1)
   initial begin
      int r, d;
      net_done = 1'b0; net_result = '0;
      forever begin
         @(negedge clk);
         if (rst_n && net_start) begin
            if (net_q.size() == 0) begin
               check(0, "net_start_unexpected", 1, 0);
            end else begin
               r = net_q.pop_front();
               d = dly_q.pop_front();
               if (r >= 0) begin
                  repeat (d) @(posedge clk);
                  #1 net_done = 1'b1; net_result = 4'(r);
                  @(posedge clk);
                  #1 net_done = 1'b0; net_result = 4'($urandom_range(0, 15));
               end
            end
         end
      end
   end

   // monitor: memory writes, start gating, error pulses, result port
   always @(negedge clk) begin
      if (!rst_n) begin
         we_cnt = 0; hs_prev = 0; held = 0;
      end else begin
         if (hs_prev) check(m_valid == 1'b0, "m_valid_drop", m_valid, 0);
         hs_prev = 0;
         if (net_mem_rst) begin rst_cnt++; we_cnt = 0; end
         if (net_mem_we) begin
            we_cnt++;
            if (exp_w_q.size() == 0) check(0, "we_extra", net_mem_wdata, -1);
            else begin
               mon_w = exp_w_q.pop_front();
               check(net_mem_wdata == mon_w, "wdata", net_mem_wdata, mon_w);
            end
         end
         if (net_start) begin
            start_cnt++;
            start_cyc = cyc;
            check(we_cnt == N, "writes_before_start", we_cnt, N);
            check(m_valid == 1'b0, "start_gated_by_m_valid", m_valid, 0);
         end
         if (err_short) got_short++;
         if (err_long) got_long++;
         if (err_timeout) begin
            got_tmo++;
            check(cyc - start_cyc == TMO + 1, "timeout_cycle", cyc - start_cyc, TMO + 1);
         end
         if (m_valid) begin
            if (held) check(m_result == held_val, "m_result_stable", m_result, held_val);
            held = 1; held_val = m_result;
            if (m_ready) begin
               if (exp_res_q.size() == 0) check(0, "result_extra", m_result, -1);
               else begin
                  mon_r = exp_res_q.pop_front();
                  check(m_result == mon_r, "result", m_result, mon_r);
               end
               hs_prev = 1; held = 0;
            end
         end
      end
   end

   task automatic send_px(input logic [7:0] d, input logic last);
      int n = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      @(negedge clk);
      while (!s_ready && n < 1000) begin @(negedge clk); n++; end
      if (!s_ready) begin
         check(0, "s_ready_wait", 0, 1);
         report_and_finish();
      end
      @(posedge clk); #1;
   endtask

   // Sends len pixels (s_last on the final one); abort_at>0 stops after that many.
   task automatic send_frame(input int len, input int res, input int dly, input int abort_at);
      logic [7:0] px[$];
      for (int i = 0; i < len; i++) px.push_back(8'($urandom_range(0, 255)));
      exp_rst++;
      for (int i = 0; i < N; i++) exp_w_q.push_back(i < len ? px[i] : 8'h00);
      if (abort_at == 0) begin
         if (len < N) exp_short++;
         if (len > N) exp_long++;
      end
      for (int i = 0; i < len; i++) begin
         if (abort_at != 0 && i == abort_at) break;
         send_px(px[i], i == len - 1);
      end
      s_valid = 1'b0; s_last = 1'b0;
      if (abort_at == 0) begin
         net_q.push_back(res); dly_q.push_back(dly);
         if (res >= 0) exp_res_q.push_back(4'(res)); else exp_tmo++;
         exp_start++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || m_valid || exp_res_q.size() != 0) && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) begin
         check(0, "idle_wait", busy, 0);
         report_and_finish();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic g_frame();
      logic [7:0] px[GN];
      int idx = 0, first_hs = -1, last_hs = 0, last_we = -1, nwe = 0;
      for (int i = 0; i < GN; i++) px[i] = 8'($urandom_range(1, 255));
      g_s_data = px[0]; g_s_last = (GN == 1); g_s_valid = 1'b1;
      for (int c = 0; c < 200 && nwe < GN; c++) begin
         @(negedge clk);
         if (g_net_mem_we) begin
            check(g_net_mem_wdata == px[nwe], "gap_wdata", g_net_mem_wdata, px[nwe]);
            if (last_we >= 0) check(cyc - last_we == GGAP + 1, "gap_we_spacing", cyc - last_we, GGAP + 1);
            last_we = cyc; nwe++;
         end
         if (g_s_valid && g_s_ready) begin
            if (first_hs < 0) first_hs = cyc;
            else check(cyc - last_hs == GGAP + 1, "gap_hs_spacing", cyc - last_hs, GGAP + 1);
            last_hs = cyc; idx++;
            @(posedge clk); #1;
            if (idx < GN) begin g_s_data = px[idx]; g_s_last = (idx == GN - 1); end
            else g_s_valid = 1'b0;
         end
      end
      g_s_valid = 1'b0;
      check(nwe == GN, "gap_we_count", nwe, GN);
      check(last_hs - first_hs == (GN - 1) * (GGAP + 1), "gap_frame_time", last_hs - first_hs, (GN - 1) * (GGAP + 1));
   endtask

   task automatic g_no_start(input string name);
      int ns = 0;
      repeat (10) begin @(negedge clk); if (g_net_start) ns++; end
      check(ns == 0 && g_busy, name, ns, 0);
   endtask

   task automatic g_run(input logic [3:0] res);
      int ns = 0, got = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (g_m_valid) begin
            got++;
            check(g_m_result == res, "gap_result", g_m_result, res);
         end
         if (g_net_start) begin
            ns++;
            @(posedge clk); #1 g_net_done = 1'b1; g_net_result = res;
            @(posedge clk); #1 g_net_done = 1'b0;
         end
      end
      check(ns == 1, "gap_start_count", ns, 1);
      check(got == 1, "gap_result_count", got, 1);
   endtask

   initial begin
      int sc, len, sel;
      rst_n = 1'b0;
      s_valid = 0; s_data = 0; s_last = 0; start_req = 0;
      g_s_valid = 0; g_s_data = 0; g_s_last = 0; g_start_req = 0; g_m_ready = 1;
      g_net_done = 0; g_net_result = 0;
      repeat (3) @(posedge clk); #1;
      check(main_outs() == '0, "reset_outputs", main_outs(), 0);
      check({g_s_ready, g_busy, g_m_valid, g_net_start, g_net_mem_we} == '0, "gap_reset_outputs",
            {g_s_ready, g_busy, g_m_valid, g_net_start, g_net_mem_we}, 0);
      @(posedge clk); #2 rst_n = 1'b1;

      // full frame, result held under back-pressure
      rdy_force0 = 1;
      send_frame(N, 7, 50, 0);
      sc = 0;
      while (!m_valid && sc < 2000) begin @(negedge clk); sc++; end
      repeat (3) begin
         @(negedge clk);
         check(m_valid === 1'b1 && m_result == 4'd7, "hold_result", m_result, 7);
      end
      rdy_force0 = 0;
      wait_idle();

      send_frame(10, $urandom_range(0, 9), $urandom_range(1, 80), 0);   // short
      wait_idle();
      send_frame(790, $urandom_range(0, 9), $urandom_range(1, 80), 0);  // long
      wait_idle();
      for (int f = 0; f < 4; f++) begin
         sel = $urandom_range(0, 2);
         len = (sel == 0) ? N : (sel == 1) ? $urandom_range(2, N - 1) : $urandom_range(N + 1, N + 16);
         send_frame(len, $urandom_range(0, 9), $urandom_range(1, 80), 0);
         wait_idle();
      end

      // second frame loads while the first result is unconsumed
      rdy_force0 = 1;
      send_frame(N, $urandom_range(0, 9), $urandom_range(1, 80), 0);
      send_frame(N, $urandom_range(0, 9), $urandom_range(1, 80), 0);
      sc = start_cnt;
      repeat (20) @(negedge clk);
      check(start_cnt == sc, "start_waits_for_handshake", start_cnt, sc);
      check(m_valid && busy, "pending_result_and_busy", {m_valid, busy}, 3);
      rdy_force0 = 0;
      wait_idle();

      // reset in the middle of loading
      send_frame(N, 0, 0, 300);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check(main_outs() == '0, "abort_outputs", main_outs(), 0);
      exp_w_q.delete();
      @(posedge clk); #2 rst_n = 1'b1;
      send_frame(N, $urandom_range(0, 9), 50, 0);
      wait_idle();

      // net_proc never answers
      send_frame(N, -1, 0, 0);
      wait_idle();

      // paced writes and manual start
      g_frame();
      g_no_start("manual_start_waits");
      g_start_req = 1'b1;
      g_run(4'($urandom_range(0, 9)));
      g_frame();
      g_no_start("held_start_no_retrigger");
      @(negedge clk) g_start_req = 1'b0;
      @(negedge clk) g_start_req = 1'b1;
      g_run(4'($urandom_range(0, 9)));

      check(got_short == exp_short, "err_short_count", got_short, exp_short);
      check(got_long == exp_long, "err_long_count", got_long, exp_long);
      check(got_tmo == exp_tmo, "err_timeout_count", got_tmo, exp_tmo);
      check(rst_cnt == exp_rst, "mem_rst_count", rst_cnt, exp_rst);
      check(start_cnt == exp_start, "start_count", start_cnt, exp_start);
      check(exp_w_q.size() == 0, "writes_outstanding", exp_w_q.size(), 0);
      check(exp_res_q.size() == 0, "results_outstanding", exp_res_q.size(), 0);
      report_and_finish();
   end

   initial begin
      #2000000;
      check(0, "global_time_limit", 0, 1);
      report_and_finish();
   end
endmodule
